// File: rtl/cdb_arbiter_pkg.sv
// Shared out-of-order core types for the common data bus and its producer-side holding registers.
package cdb_arbiter_pkg;

  // Tag width matches the RS_ENTRY_ID format used by every reservation station.
  localparam int CDB_TAG_W   = 16;
  localparam int CDB_DATA_W  = 32;
  localparam int STALL_CNT_W = 16;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_bus_t;

  typedef struct packed {
    logic                  occ;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_hold_t;

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr (wrapping) wins.
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  int            j;
  logic [IW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = 0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      idx = j[IW-1:0];
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: one holding register per functional unit, round-robin broadcast of one result per cycle.
// Optional CDB_STALL_CNT_EN adds per-unit saturating stall counters on port stall_cnt.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int BITWIDTH = CDB_DATA_W,
  parameter int TAG_W    = CDB_TAG_W,
  parameter int N_FU     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [N_FU-1:0]            fu_valid,
  output logic [N_FU-1:0]            fu_ready,
  input  logic [N_FU*TAG_W-1:0]      fu_tag,
  input  logic [N_FU*BITWIDTH-1:0]   fu_data,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [BITWIDTH-1:0]        cdb_data,
  output logic [$clog2(N_FU)-1:0]    cdb_src
`ifdef CDB_STALL_CNT_EN
  ,
  output logic [N_FU*STALL_CNT_W-1:0] stall_cnt
`endif
);

  localparam int SRC_W = $clog2(N_FU);

  // Handshake: a unit transfers on a rising edge where fu_valid & fu_ready; while
  // blocked it must hold tag/data stable. The CDB itself has no backpressure.
  logic [N_FU-1:0]     occ;
  logic [TAG_W-1:0]    hold_tag  [N_FU];
  logic [BITWIDTH-1:0] hold_data [N_FU];
  logic [SRC_W-1:0]    rr_ptr;
  logic [SRC_W-1:0]    rr_next;
  logic [N_FU-1:0]     grant;
  logic [SRC_W-1:0]    grant_idx;
  logic                grant_any;
  logic [N_FU-1:0]     accept;

  rr_arbiter #(.N(N_FU)) u_rr (
    .req       (occ),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  // A hold being drained this cycle can be refilled on the same edge.
  assign fu_ready = (~occ | grant) & {N_FU{~flush}};
  assign accept   = fu_valid & fu_ready;
  assign rr_next  = (grant_idx == SRC_W'(N_FU - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      occ <= accept | (occ & ~grant);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_FU; i++) begin
      if (accept[i]) begin
        hold_tag[i]  <= fu_tag[i*TAG_W +: TAG_W];
        hold_data[i] <= fu_data[i*BITWIDTH +: BITWIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_data  <= '0;
      cdb_src   <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      cdb_valid <= 1'b0;
    end else begin
      cdb_valid <= grant_any;
      if (grant_any) begin
        cdb_tag  <= hold_tag[grant_idx];
        cdb_data <= hold_data[grant_idx];
        cdb_src  <= grant_idx;
        rr_ptr   <= rr_next;
      end
    end
  end

`ifdef CDB_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q [N_FU];

  // Flush deliberately leaves these alone; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_FU; i++) stall_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_FU; i++) begin
        if (fu_valid[i] && !fu_ready[i] && (stall_q[i] != '1)) stall_q[i] <= stall_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N_FU; g++) begin : g_stall
    assign stall_cnt[g*STALL_CNT_W +: STALL_CNT_W] = stall_q[g];
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: cycle vector table plus scoreboarded streaming, fairness and reset sequences.
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [3:0]   fu_valid;
  logic [3:0]   fu_ready;
  logic [63:0]  fu_tag;
  logic [127:0] fu_data;
  logic         cdb_valid;
  logic [15:0]  cdb_tag;
  logic [31:0]  cdb_data;
  logic [1:0]   cdb_src;
`ifdef CDB_STALL_CNT_EN
  logic [63:0]  stall_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  cdb_arbiter #(.BITWIDTH(32), .TAG_W(16), .N_FU(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_ready  (fu_ready),
    .fu_tag    (fu_tag),
    .fu_data   (fu_data),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
`ifdef CDB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // FU-side protocol: a blocked unit keeps tag/data stable.
  logic [3:0]   pv;
  logic [3:0]   pr;
  logic [63:0]  pt;
  logic [127:0] pd;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst && pv[i] && !pr[i] && fu_valid[i])
        assert (fu_tag[i*16 +: 16] == pt[i*16 +: 16] && fu_data[i*32 +: 32] == pd[i*32 +: 32])
          else $error("FAIL fu_hold_stable unit %0d", i);
    end
    pv <= fu_valid;
    pr <= fu_ready;
    pt <= fu_tag;
    pd <= fu_data;
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: broadcast with no expected entry", name);
  endtask

  function automatic logic [31:0] dv(input logic [15:0] t);
    return 32'hA500_0000 | {16'h0000, t};
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic         flush;
    logic [3:0]   valid;
    logic [63:0]  tags;
    logic [127:0] data;
    logic [3:0]   ready;
    logic         cv;
    logic [15:0]  ctag;
    logic [31:0]  cdata;
    logic [1:0]   csrc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic f, input logic [3:0] v, input logic [63:0] t, input logic [127:0] d,
                     input logic [3:0] r, input logic cv, input logic [15:0] ct, input logic [31:0] cd,
                     input logic [1:0] cs);
    vec_t x;
    x.flush = f;  x.valid = v; x.tags = t;   x.data = d;
    x.ready = r;  x.cv = cv;   x.ctag = ct;  x.cdata = cd; x.csrc = cs;
    vecs.push_back(x);
  endtask

  // Inputs for one cycle, fu_ready during it, then CDB outputs after the following edge.
  task automatic run_vec(input int idx, input vec_t x);
    @(negedge clk);
    flush    = x.flush;
    fu_valid = x.valid;
    fu_tag   = x.tags;
    fu_data  = x.data;
    #1;
    check($sformatf("v%0d_ready", idx), 64'(fu_ready), 64'(x.ready));
    @(posedge clk);
    #1;
    check($sformatf("v%0d_cdb_valid", idx), 64'(cdb_valid), 64'(x.cv));
    check($sformatf("v%0d_cdb_tag", idx), 64'(cdb_tag), 64'(x.ctag));
    check($sformatf("v%0d_cdb_data", idx), 64'(cdb_data), 64'(x.cdata));
    check($sformatf("v%0d_cdb_src", idx), 64'(cdb_src), 64'(x.csrc));
  endtask

  task automatic idle_inputs();
    flush    = 1'b0;
    fu_valid = 4'b0000;
    fu_tag   = '0;
    fu_data  = '0;
  endtask

  // ---------------- scoreboard ----------------
  logic [47:0] exp_q[$];
  logic [47:0] q_u0[$];
  logic [47:0] q_u3[$];

  task automatic pop_unit(input string name);
    logic [47:0] e;
    if (cdb_src == 2'd0 && q_u0.size() != 0) begin
      e = q_u0.pop_front();
      check(name, 64'({cdb_tag, cdb_data}), 64'(e));
    end else if (cdb_src == 2'd3 && q_u3.size() != 0) begin
      e = q_u3.pop_front();
      check(name, 64'({cdb_tag, cdb_data}), 64'(e));
    end else begin
      fail(name);
    end
  endtask

  int n0;
  int n3;
  int bcast;
  int first_e;
  int last_e;

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    check("rst_cdb_data", 64'(cdb_data), 64'd0);
    check("rst_cdb_src", 64'(cdb_src), 64'd0);
    check("rst_fu_ready", 64'(fu_ready), 64'hF);
`ifdef CDB_STALL_CNT_EN
    check("rst_stall_cnt", stall_cnt, 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // All four units at once from rr_ptr=0: strict rotation 0..3.
    add(0, 4'b1111, {16'h13, 16'h12, 16'h11, 16'h10}, {dv(16'h13), dv(16'h12), dv(16'h11), dv(16'h10)},
        4'b1111, 0, 16'h0000, 32'h0, 2'd0);
    add(0, 4'b0000, 64'h0, 128'h0, 4'b0001, 1, 16'h10, dv(16'h10), 2'd0);
    add(0, 4'b0000, 64'h0, 128'h0, 4'b0011, 1, 16'h11, dv(16'h11), 2'd1);
    add(0, 4'b0000, 64'h0, 128'h0, 4'b0111, 1, 16'h12, dv(16'h12), 2'd2);
    add(0, 4'b0000, 64'h0, 128'h0, 4'b1111, 1, 16'h13, dv(16'h13), 2'd3);
    add(0, 4'b0000, 64'h0, 128'h0, 4'b1111, 0, 16'h13, dv(16'h13), 2'd3);
    // Single result on unit 1, one-cycle latency, then tag/data/src hold with valid low.
    add(0, 4'b0010, {16'h0, 16'h0, 16'h0103, 16'h0}, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0},
        4'b1111, 0, 16'h13, dv(16'h13), 2'd3);
    add(0, 4'b0000, 64'h0, 128'h0, 4'b1111, 1, 16'h0103, 32'hDEADBEEF, 2'd1);
    add(0, 4'b0000, 64'h0, 128'h0, 4'b1111, 0, 16'h0103, 32'hDEADBEEF, 2'd1);
    // Fill 0..2 then flush; unit 3 data offered during flush is dropped.
    add(0, 4'b0111, {16'h0, 16'h22, 16'h21, 16'h20}, {32'h0, dv(16'h22), dv(16'h21), dv(16'h20)},
        4'b1111, 0, 16'h0103, 32'hDEADBEEF, 2'd1);
    add(1, 4'b1000, {16'h33, 16'h0, 16'h0, 16'h0}, {dv(16'h33), 32'h0, 32'h0, 32'h0},
        4'b0000, 0, 16'h0103, 32'hDEADBEEF, 2'd1);
    add(0, 4'b0000, 64'h0, 128'h0, 4'b1111, 0, 16'h0103, 32'hDEADBEEF, 2'd1);
    add(0, 4'b0000, 64'h0, 128'h0, 4'b1111, 0, 16'h0103, 32'hDEADBEEF, 2'd1);
    // rr_ptr survives flush at 2: unit 3 beats unit 1.
    add(0, 4'b1010, {16'h43, 16'h0, 16'h41, 16'h0}, {dv(16'h43), 32'h0, dv(16'h41), 32'h0},
        4'b1111, 0, 16'h0103, 32'hDEADBEEF, 2'd1);
    add(0, 4'b0000, 64'h0, 128'h0, 4'b1101, 1, 16'h43, dv(16'h43), 2'd3);
    add(0, 4'b0000, 64'h0, 128'h0, 4'b1111, 1, 16'h41, dv(16'h41), 2'd1);
    add(0, 4'b0000, 64'h0, 128'h0, 4'b1111, 0, 16'h41, dv(16'h41), 2'd1);

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    // Unit 2 streams 8 back-to-back results.
    bcast   = 0;
    first_e = -1;
    last_e  = -1;
    for (int e = 0; e < 12; e++) begin
      @(negedge clk);
      if (e < 8) begin
        fu_valid          = 4'b0100;
        fu_tag[32 +: 16]  = 16'h0200 + e[15:0];
        fu_data[64 +: 32] = 32'h5000_0000 + 32'($urandom_range(0, 16'hFFFF)) * 32'h100 + 32'(e);
      end else begin
        fu_valid = 4'b0000;
      end
      #1;
      if (e < 8) begin
        check("stream_ready2", 64'(fu_ready[2]), 64'd1);
        if (fu_ready[2]) exp_q.push_back({fu_tag[32 +: 16], fu_data[64 +: 32]});
      end
      @(posedge clk);
      #1;
      if (cdb_valid) begin
        if (first_e < 0) first_e = e;
        last_e = e;
        bcast++;
        check("stream_src", 64'(cdb_src), 64'd2);
        if (exp_q.size() == 0) fail("stream_result");
        else check("stream_result", 64'({cdb_tag, cdb_data}), 64'(exp_q.pop_front()));
      end
    end
    check("stream_count", 64'(bcast), 64'd8);
    check("stream_first_edge", 64'(first_e), 64'd1);
    check("stream_span", 64'(last_e - first_e), 64'd7);

    // One unit 1 result moves rr_ptr from 3 to 2.
    @(negedge clk);
    fu_valid         = 4'b0010;
    fu_tag[16 +: 16] = 16'h0111;
    @(posedge clk);
    @(negedge clk);
    fu_valid = 4'b0000;
    @(posedge clk);
    #1;
    check("prelude_valid", 64'(cdb_valid), 64'd1);
    check("prelude_src", 64'(cdb_src), 64'd1);

    // Units 0 and 3 continuously valid from rr_ptr=2: grants 3,0,3,0...
    n0 = 0;
    n3 = 0;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      fu_valid           = 4'b1001;
      fu_tag[0 +: 16]    = 16'h0A00 + n0[15:0];
      fu_tag[48 +: 16]   = 16'h3A00 + n3[15:0];
      fu_data[0 +: 32]   = 32'h0A0A_0000 + 32'(n0);
      fu_data[96 +: 32]  = 32'h3A3A_0000 + 32'(n3);
      #1;
      if (fu_ready[0]) begin
        q_u0.push_back({fu_tag[0 +: 16], fu_data[0 +: 32]});
        n0++;
      end
      if (fu_ready[3]) begin
        q_u3.push_back({fu_tag[48 +: 16], fu_data[96 +: 32]});
        n3++;
      end
      @(posedge clk);
      #1;
      if (e >= 1) begin
        check($sformatf("alt_valid_%0d", e), 64'(cdb_valid), 64'd1);
        check($sformatf("alt_src_%0d", e), 64'(cdb_src), (e % 2 == 1) ? 64'd3 : 64'd0);
      end
      if (cdb_valid) pop_unit("alt_result");
    end
    @(negedge clk);
    fu_valid = 4'b0000;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk);
      #1;
      if (cdb_valid) pop_unit("alt_drain");
      @(negedge clk);
    end
    check("alt_q0_empty", 64'(q_u0.size()), 64'd0);
    check("alt_q3_empty", 64'(q_u3.size()), 64'd0);

    // Reset mid-stream with three holds full.
    @(negedge clk);
    fu_valid = 4'b0111;
    fu_tag   = {16'h0, 16'h62, 16'h61, 16'h60};
    fu_data  = {32'h0, dv(16'h62), dv(16'h61), dv(16'h60)};
    @(negedge clk);
    idle_inputs();
    @(posedge clk);
    #1;
    check("pre_rst_valid", 64'(cdb_valid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("midrst_cdb_tag", 64'(cdb_tag), 64'd0);
    check("midrst_cdb_data", 64'(cdb_data), 64'd0);
    check("midrst_cdb_src", 64'(cdb_src), 64'd0);
    check("midrst_fu_ready", 64'(fu_ready), 64'hF);
    @(posedge clk);
    #1;
    check("midrst_ready_hold", 64'(fu_ready), 64'hF);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_empty", 64'(cdb_valid), 64'd0);

`ifdef CDB_STALL_CNT_EN
    check("stall_cnt_after_rst", stall_cnt, 64'd0);
    @(negedge clk);
    fu_valid = 4'b1111;
    fu_tag   = {16'h13, 16'h12, 16'h11, 16'h10};
    fu_data  = {dv(16'h13), dv(16'h12), dv(16'h11), dv(16'h10)};
    @(negedge clk);
    fu_valid          = 4'b1000;
    fu_tag[48 +: 16]  = 16'h003F;
    fu_data[96 +: 32] = dv(16'h003F);
    repeat (4) @(negedge clk);
    fu_valid = 4'b0000;
    #1;
    check("stall_cnt_u3", 64'(stall_cnt[48 +: 16]), 64'd3);
    check("stall_cnt_others", 64'(stall_cnt[47:0]), 64'd0);
    repeat (6) @(negedge clk);
`endif

    // First new input after reset broadcasts normally.
    @(negedge clk);
    fu_valid          = 4'b0100;
    fu_tag[32 +: 16]  = 16'h0077;
    fu_data[64 +: 32] = dv(16'h0077);
    @(posedge clk);
    #1;
    check("post_rst_e0_valid", 64'(cdb_valid), 64'd0);
    @(negedge clk);
    fu_valid = 4'b0000;
    @(posedge clk);
    #1;
    check("post_rst_valid", 64'(cdb_valid), 64'd1);
    check("post_rst_tag", 64'(cdb_tag), 64'h0077);
    check("post_rst_data", 64'(cdb_data), 64'(dv(16'h0077)));
    check("post_rst_src", 64'(cdb_src), 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
